avalon_mm_burst_slave: RTL and testbench

AVALON_MM_BURST_SLAVE -- requirements
Module: avalon_mm_burst_slave

---
 rtl/avalon_mm_burst_slave.sv | 159 +++++++++++++++
 tb/tb_avalon_mm_burst_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_burst_slave.sv
// Avalon-MM burst-capable memory slave: on-chip word memory with sequential
// read/write bursts, per-byte write enables and a protocol-error pulse.
module avalon_mm_burst_slave #(
    parameter int DATA_WIDTH          = 32,
    parameter int ADDRESS_WIDTH       = 10,
    parameter int BURST_COUNT_WIDTH   = 3,
    parameter int MAXIMUM_BURST_COUNT = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDRESS_WIDTH-1:0]     slave_address,
    input  logic                         slave_read,
    input  logic                         slave_write,
    input  logic [DATA_WIDTH/8-1:0]      slave_byteenable,
    input  logic [DATA_WIDTH-1:0]        slave_writedata,
    input  logic [BURST_COUNT_WIDTH-1:0] slave_burstcount,
    input  logic                         slave_stall,
    output logic                         slave_waitrequest,
    output logic [DATA_WIDTH-1:0]        slave_readdata,
    output logic                         slave_readdatavalid,
    output logic                         slave_protocol_error
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDRESS_WIDTH;
    localparam logic [BURST_COUNT_WIDTH-1:0] MAX_LEN = BURST_COUNT_WIDTH'(MAXIMUM_BURST_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        READ_BURST,
        WRITE_BURST
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       addr_q, addr_d;
    logic [BURST_COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic                           rvalid_q, rvalid_d;
    logic                           error_q, error_d;

    logic                           bc_illegal;
    logic [BURST_COUNT_WIDTH-1:0]   burst_len;
    logic                           rd_en;
    logic                           wr_en;
    logic [ADDRESS_WIDTH-1:0]       rd_addr;
    logic [ADDRESS_WIDTH-1:0]       wr_addr;

    assign slave_waitrequest    = !reset_n || (state_q == READ_BURST) || slave_stall;
    assign slave_readdatavalid  = rvalid_q;
    assign slave_protocol_error = error_q;

    always_comb begin
        bc_illegal = (slave_burstcount == '0) || (slave_burstcount > MAX_LEN);
        burst_len  = slave_burstcount;
        if (slave_burstcount == '0) begin
            burst_len = BURST_COUNT_WIDTH'(1);
        end else if (slave_burstcount > MAX_LEN) begin
            burst_len = MAX_LEN;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        rvalid_d    = 1'b0;
        error_d     = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        rd_addr     = addr_q;
        wr_addr     = addr_q;
        case (state_q)
            IDLE: begin
                // A read wins over a simultaneous write; the write is dropped.
                if (!slave_waitrequest && slave_read) begin
                    rd_en       = 1'b1;
                    rd_addr     = slave_address;
                    rvalid_d    = 1'b1;
                    addr_d      = slave_address + 1'b1;
                    remaining_d = burst_len - 1'b1;
                    state_d     = READ_BURST;
                    error_d     = bc_illegal || slave_write;
                end else if (!slave_waitrequest && slave_write) begin
                    wr_en   = 1'b1;
                    wr_addr = slave_address;
                    error_d = bc_illegal;
                    if (burst_len > BURST_COUNT_WIDTH'(1)) begin
                        addr_d      = slave_address + 1'b1;
                        remaining_d = burst_len - 1'b1;
                        state_d     = WRITE_BURST;
                    end
                end
            end
            READ_BURST: begin
                if (remaining_q != '0) begin
                    rd_en       = 1'b1;
                    rvalid_d    = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE_BURST: begin
                error_d = slave_read;
                if (slave_write && !slave_stall) begin
                    wr_en       = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == BURST_COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rvalid_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rvalid_q    <= rvalid_d;
            error_q     <= error_d;
        end
    end

    // One narrow RAM per byte lane keeps byte-enabled writes single-driver.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (wr_en && slave_byteenable[gi]) begin
                    mem[wr_addr] <= slave_writedata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= mem[rd_addr];
                end
            end

            assign slave_readdata[gi*8 +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_avalon_mm_burst_slave.sv
// Directed self-checking bench for avalon_mm_burst_slave (default parameters).
module tb_avalon_mm_burst_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [3:0]  slave_byteenable;
    logic [31:0] slave_writedata;
    logic [2:0]  slave_burstcount;
    logic        slave_stall;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        slave_protocol_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_mm_burst_slave dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_byteenable     (slave_byteenable),
        .slave_writedata      (slave_writedata),
        .slave_burstcount     (slave_burstcount),
        .slave_stall          (slave_stall),
        .slave_waitrequest    (slave_waitrequest),
        .slave_readdata       (slave_readdata),
        .slave_readdatavalid  (slave_readdatavalid),
        .slave_protocol_error (slave_protocol_error)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
        slave_address    = addr;
        slave_writedata  = data;
        slave_byteenable = be;
        slave_burstcount = 3'd1;
        slave_write      = 1'b1;
        cyc();
        slave_write = 1'b0;
        $display("WR addr %0d data %h be %h", addr, data, be);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        slave_read = 0; slave_write = 0; slave_stall = 0;
        slave_address = '0; slave_byteenable = '0; slave_writedata = '0; slave_burstcount = 3'd1;
        cyc(); cyc();
        checks++;
        if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq got %b exp 1", slave_waitrequest); end
        checks++;
        if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", slave_readdatavalid); end
        checks++;
        if (slave_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", slave_readdata); end
        checks++;
        if (slave_protocol_error !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", slave_protocol_error); end
        reset_n = 1'b1;
        #1;
        checks++;
        if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_release_waitreq got %b exp 0", slave_waitrequest); end
        $display("RESET done");
    endtask

    task automatic test_single();
        write_word(10'd5, 32'hA5A5A5A5, 4'hF);
        slave_address = 10'd5; slave_burstcount = 3'd1; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        checks++;
        if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL single_rd got v=%b d=%h exp v=1 d=a5a5a5a5", slave_readdatavalid, slave_readdata);
        end
        checks++;
        if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL single_rd_waitreq got %b exp 1", slave_waitrequest); end
        cyc();
        checks++;
        if (slave_readdatavalid !== 1'b0 || slave_waitrequest !== 1'b0) begin
            errors++; $display("FAIL single_rd_end got v=%b w=%b exp v=0 w=0", slave_readdatavalid, slave_waitrequest);
        end
        checks++;
        if (slave_readdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rdata_hold got %h exp a5a5a5a5", slave_readdata); end
        $display("RD addr 5 len 1 data %h", slave_readdata);
    endtask

    task automatic test_write_burst_wrap();
        logic [31:0] exp [4];
        exp[0] = 32'd1; exp[1] = 32'd2; exp[2] = 32'd3; exp[3] = 32'd4;
        write_word(10'd7, 32'h77777777, 4'hF);
        slave_address = 10'd1022; slave_burstcount = 3'd4; slave_byteenable = 4'hF;
        slave_writedata = 32'd1; slave_write = 1'b1;
        cyc();
        slave_address = 10'd7; slave_burstcount = 3'd1;
        slave_writedata = 32'd2;
        cyc();
        slave_writedata = 32'd3; slave_stall = 1'b1;
        #1;
        checks++;
        if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_waitreq got %b exp 1", slave_waitrequest); end
        cyc(); cyc();
        slave_stall = 1'b0;
        cyc();
        slave_writedata = 32'd4;
        cyc();
        slave_write = 1'b0;
        checks++;
        if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL wrburst_done_waitreq got %b exp 0", slave_waitrequest); end
        $display("WR burst addr 1022 len 4 with stall");
        slave_address = 10'd1022; slave_burstcount = 3'd4; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slave_readdatavalid !== 1'b1 || slave_readdata !== exp[i]) begin
                errors++; $display("FAIL wrap_rd beat %0d got v=%b d=%h exp v=1 d=%h", i, slave_readdatavalid, slave_readdata, exp[i]);
            end
            cyc();
        end
        checks++;
        if (slave_readdatavalid !== 1'b0 || slave_waitrequest !== 1'b0) begin
            errors++; $display("FAIL wrap_rd_end got v=%b w=%b exp v=0 w=0", slave_readdatavalid, slave_waitrequest);
        end
        slave_address = 10'd7; slave_burstcount = 3'd1; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        checks++;
        if (slave_readdata !== 32'h77777777) begin errors++; $display("FAIL burst_ignores_addr got %h exp 77777777", slave_readdata); end
        cyc();
        $display("RD burst addr 1022 len 4 checked");
    endtask

    task automatic test_byteenable();
        write_word(10'd8, 32'h11223344, 4'hF);
        write_word(10'd8, 32'hAABBCCDD, 4'h5);
        slave_address = 10'd8; slave_burstcount = 3'd1; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        checks++;
        if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h11BB33DD) begin
            errors++; $display("FAIL byteenable got v=%b d=%h exp v=1 d=11bb33dd", slave_readdatavalid, slave_readdata);
        end
        cyc();
        $display("RD addr 8 data %h", slave_readdata);
    endtask

    task automatic test_rw_collision();
        write_word(10'd3, 32'h33333333, 4'hF);
        checks++;
        if (slave_protocol_error !== 1'b0) begin errors++; $display("FAIL coll_err_before got %b exp 0", slave_protocol_error); end
        slave_address = 10'd3; slave_burstcount = 3'd1; slave_byteenable = 4'hF;
        slave_writedata = 32'hDEADBEEF; slave_read = 1'b1; slave_write = 1'b1;
        cyc();
        slave_read = 1'b0; slave_write = 1'b0;
        checks++;
        if (slave_protocol_error !== 1'b1 || slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h33333333) begin
            errors++; $display("FAIL coll_accept got e=%b v=%b d=%h exp e=1 v=1 d=33333333", slave_protocol_error, slave_readdatavalid, slave_readdata);
        end
        cyc();
        checks++;
        if (slave_protocol_error !== 1'b0) begin errors++; $display("FAIL coll_err_pulse got %b exp 0", slave_protocol_error); end
        slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        checks++;
        if (slave_readdata !== 32'h33333333) begin errors++; $display("FAIL coll_mem_unchanged got %h exp 33333333", slave_readdata); end
        cyc();
        $display("RD+WR collision addr 3");
    endtask

    task automatic test_reset_midburst();
        write_word(10'd20, 32'h20202020, 4'hF);
        write_word(10'd21, 32'h21212121, 4'hF);
        slave_address = 10'd20; slave_burstcount = 3'd4; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        checks++;
        if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h20202020) begin
            errors++; $display("FAIL midrst_beat1 got v=%b d=%h exp v=1 d=20202020", slave_readdatavalid, slave_readdata);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_waitreq got %b exp 1", slave_waitrequest); end
        cyc();
        reset_n = 1'b1;
        #1;
        checks++;
        if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL midrst_after_waitreq got %b exp 0", slave_waitrequest); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid cyc %0d got %b exp 0", i, slave_readdatavalid); end
            cyc();
        end
        $display("RESET during read burst");
    endtask

    task automatic test_burstcount_zero();
        slave_address = 10'd5; slave_burstcount = 3'd0; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0; slave_burstcount = 3'd1;
        checks++;
        if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'hA5A5A5A5 || slave_protocol_error !== 1'b1) begin
            errors++; $display("FAIL bc0_beat got v=%b d=%h e=%b exp v=1 d=a5a5a5a5 e=1", slave_readdatavalid, slave_readdata, slave_protocol_error);
        end
        cyc();
        checks++;
        if (slave_readdatavalid !== 1'b0 || slave_protocol_error !== 1'b0) begin
            errors++; $display("FAIL bc0_end got v=%b e=%b exp v=0 e=0", slave_readdatavalid, slave_protocol_error);
        end
        cyc();
        checks++;
        if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL bc0_extra got %b exp 0", slave_readdatavalid); end
        $display("RD addr 5 burstcount 0");
    endtask

    task automatic test_burstcount_over();
        logic [31:0] exp [4];
        exp[0] = 32'd1; exp[1] = 32'd2; exp[2] = 32'd3; exp[3] = 32'd4;
        slave_address = 10'd1022; slave_burstcount = 3'd7; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0; slave_burstcount = 3'd1;
        checks++;
        if (slave_protocol_error !== 1'b1) begin errors++; $display("FAIL bc7_err got %b exp 1", slave_protocol_error); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slave_readdatavalid !== 1'b1 || slave_readdata !== exp[i]) begin
                errors++; $display("FAIL bc7_beat %0d got v=%b d=%h exp v=1 d=%h", i, slave_readdatavalid, slave_readdata, exp[i]);
            end
            cyc();
        end
        checks++;
        if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL bc7_clamp got %b exp 0", slave_readdatavalid); end
        $display("RD addr 1022 burstcount 7 clamped");
    endtask

    task automatic test_read_in_write_burst();
        slave_address = 10'd40; slave_burstcount = 3'd2; slave_byteenable = 4'hF;
        slave_writedata = 32'h40404040; slave_write = 1'b1;
        cyc();
        slave_write = 1'b0;
        cyc();
        checks++;
        if (slave_waitrequest !== 1'b0 || slave_protocol_error !== 1'b0) begin
            errors++; $display("FAIL wrgap got w=%b e=%b exp w=0 e=0", slave_waitrequest, slave_protocol_error);
        end
        slave_writedata = 32'h41414141; slave_write = 1'b1; slave_read = 1'b1;
        cyc();
        slave_write = 1'b0; slave_read = 1'b0;
        checks++;
        if (slave_protocol_error !== 1'b1 || slave_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rd_in_wrburst got e=%b v=%b exp e=1 v=0", slave_protocol_error, slave_readdatavalid);
        end
        slave_address = 10'd41; slave_burstcount = 3'd1; slave_read = 1'b1;
        cyc();
        slave_read = 1'b0;
        checks++;
        if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h41414141) begin
            errors++; $display("FAIL wrburst_beat2 got v=%b d=%h exp v=1 d=41414141", slave_readdatavalid, slave_readdata);
        end
        cyc();
        $display("WR burst addr 40 len 2 with read during burst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_write_burst_wrap();
        test_byteenable();
        test_rw_collision();
        test_reset_midburst();
        test_burstcount_zero();
        test_burstcount_over();
        test_read_in_write_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
